// File: rtl/carry_lookahead_adder.sv
// Registered two-level carry-lookahead adder: S = A + B + Cin, one cycle latency.
// Ports: clk, rst (sync, active-high), A/B operands, Cin carry-in;
//        S sum, C_out carry-out, P_out/G_out group propagate/generate (all registered).
module carry_lookahead_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             P_out,
    output logic             G_out
);

    // WIDTH is expected to be a multiple of 4 and at least 4.
    localparam int NG = WIDTH / 4;

    // Bit-level propagate / generate.
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;

    // Carry into every bit, produced group by group.
    logic [WIDTH-1:0] c;

    // Per-group propagate / generate and carries into each group.
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;
    logic [NG:0]   grp_c;

    // Next-state values for the output registers.
    logic [WIDTH-1:0] s_d;
    logic             c_out_d;
    logic             p_out_d;
    logic             g_out_d;

    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             p_out_q;
    logic             g_out_q;

    assign p = A ^ B;
    assign g = A & B;

    // Second lookahead level. Returns the carry out of group 'top':
    //   G[top] | P[top]G[top-1] | ... | P[top..0]ci
    // The running product is only a compact way to write the expanded
    // sum of products; each term is an independent AND of group signals,
    // so synthesis builds a flat two-level network rather than a ripple.
    function automatic logic lookahead(
        input logic [NG-1:0] pv,
        input logic [NG-1:0] gv,
        input logic          ci,
        input int            top
    );
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b1;
        for (int j = top; j >= 0; j--) begin
            acc = acc | (run & gv[j]);
            run = run & pv[j];
        end
        return acc | (run & ci);
    endfunction

    assign grp_c[0] = Cin;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int B0 = 4 * k;

        logic [3:0] pk;
        logic [3:0] gk;
        logic       ck;

        assign pk = p[B0 +: 4];
        assign gk = g[B0 +: 4];
        assign ck = grp_c[k];

        // First lookahead level: carries inside the group, fully expanded.
        assign c[B0]     = ck;
        assign c[B0 + 1] = gk[0]
                         | (pk[0] & ck);
        assign c[B0 + 2] = gk[1]
                         | (pk[1] & gk[0])
                         | (pk[1] & pk[0] & ck);
        assign c[B0 + 3] = gk[2]
                         | (pk[2] & gk[1])
                         | (pk[2] & pk[1] & gk[0])
                         | (pk[2] & pk[1] & pk[0] & ck);

        // Group signals feeding the second level; independent of carry-in.
        assign grp_p[k] = &pk;
        assign grp_g[k] = gk[3]
                        | (pk[3] & gk[2])
                        | (pk[3] & pk[2] & gk[1])
                        | (pk[3] & pk[2] & pk[1] & gk[0]);

        // Carry into the next group comes straight from the group P/G
        // vectors and Cin, never from this group's internal carries.
        assign grp_c[k + 1] = lookahead(grp_p, grp_g, Cin, k);
    end

    always_comb begin
        s_d     = p ^ c;
        c_out_d = grp_c[NG];
        p_out_d = &grp_p;
        // Whole-word generate: the same lookahead with carry-in forced low.
        g_out_d = lookahead(grp_p, grp_g, 1'b0, NG - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            p_out_q <= 1'b0;
            g_out_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
            p_out_q <= p_out_d;
            g_out_q <= g_out_d;
        end
    end

    assign S     = s_q;
    assign C_out = c_out_q;
    assign P_out = p_out_q;
    assign G_out = g_out_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench for carry_lookahead_adder (WIDTH=4).
// Arithmetic reference model; directed, exhaustive and random stimulus.
module tb_carry_lookahead_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c_out;
    logic         p_out;
    logic         g_out;

    int checks;
    int failures;

    carry_lookahead_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .S     (s),
        .C_out (c_out),
        .P_out (p_out),
        .G_out (g_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic.
    // {C,S} = A+B+Cin; P: every bit pair differs, so a carry-in would pass
    // straight through; G: A+B alone already overflows.
    function automatic logic [W+2:0] model(
        input logic [W-1:0] ma,
        input logic [W-1:0] mb,
        input logic         mc
    );
        int sum;
        int sum0;
        logic pp;
        logic gg;
        sum  = int'(ma) + int'(mb) + int'(mc);
        sum0 = int'(ma) + int'(mb);
        pp   = ((ma ^ mb) == {W{1'b1}});
        gg   = (sum0 >= (1 << W));
        return {pp, gg, sum[W], sum[W-1:0]};
    endfunction

    task automatic drive(
        input logic [W-1:0] da,
        input logic [W-1:0] db,
        input logic         dc
    );
        @(negedge clk);
        a   = da;
        b   = db;
        cin = dc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(4'hF, 4'hF, 1'b1);
        drive(4'h9, 4'h6, 1'b1);
        checks++;
        if ({p_out, g_out, c_out, s} !== 7'b0) begin
            failures++;
            $display("FAIL reset: got P=%b G=%b C=%b S=%b, want all 0",
                     p_out, g_out, c_out, s);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         tc [4];
        logic [6:0]   te [4];
        ta = '{4'b0000, 4'b0101, 4'b1001, 4'b1111};
        tb = '{4'b0000, 4'b0011, 4'b0110, 4'b1111};
        tc = '{1'b0, 1'b0, 1'b1, 1'b1};
        // {P,G,C,S} from the hand-worked cases.
        te = '{7'b000_0000, 7'b000_1000, 7'b101_0000, 7'b011_1111};
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i], tc[i]);
            checks++;
            if ({p_out, g_out, c_out, s} !== te[i]) begin
                failures++;
                $display("FAIL directed%0d: got PGCS=%b, want %b",
                         i, {p_out, g_out, c_out, s}, te[i]);
            end
        end
    endtask

    task automatic test_exhaustive;
        int bad;
        int inv_bad;
        logic [6:0] exp;
        bad     = 0;
        inv_bad = 0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive(v[3:0], v[7:4], v[8]);
            exp = model(v[3:0], v[7:4], v[8]);
            if ({p_out, g_out, c_out, s} !== exp) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL exhaustive A=%h B=%h Cin=%b: got PGCS=%b, want %b",
                             v[3:0], v[7:4], v[8], {p_out, g_out, c_out, s}, exp);
            end
            if (c_out !== (g_out | (p_out & v[8]))) inv_bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL exhaustive: %0d of 512 wrong, want 0", bad);
        end
        checks++;
        if (inv_bad != 0) begin
            failures++;
            $display("FAIL invariant: %0d violations, want 0", inv_bad);
        end
    endtask

    task automatic test_back_to_back_random;
        int bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [6:0]   exp;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc);
            exp = model(ra, rb, rc);
            if ({p_out, g_out, c_out, s} !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random: %0d of 200 wrong, want 0", bad);
        end
    endtask

    task automatic test_mid_reset;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [6:0]   exp;
        drive(4'hF, 4'h1, 1'b1);
        checks++;
        if ({p_out, g_out, c_out, s} !== model(4'hF, 4'h1, 1'b1)) begin
            failures++;
            $display("FAIL pre_reset: got PGCS=%b, want %b",
                     {p_out, g_out, c_out, s}, model(4'hF, 4'h1, 1'b1));
        end
        @(negedge clk);
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({p_out, g_out, c_out, s} !== 7'b0) begin
            failures++;
            $display("FAIL mid_reset: got PGCS=%b, want 0000000",
                     {p_out, g_out, c_out, s});
        end
        ra = 4'hA;
        rb = 4'h5;
        @(negedge clk);
        rst = 1'b0;
        drive(ra, rb, 1'b1);
        exp = model(ra, rb, 1'b1);
        checks++;
        if ({p_out, g_out, c_out, s} !== exp) begin
            failures++;
            $display("FAIL post_reset: got PGCS=%b, want %b",
                     {p_out, g_out, c_out, s}, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
